regfile_mp: RTL and testbench

- Parametrised multi-read-port integer register file; next generation of the core's two-read/one-write file.
- Adds a hardware zero-clear sequencer after reset or flush, a per-register busy scoreboard for pending writebacks, and optional write-to-read bypass.
- Sits between decode (reads, issue marking) and writeback (single write port).

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 126 ++++++++++++
 tb/tb_regfile_mp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv package
// Shared types for the integer register file slice.
//   word_t             default-width data word (32 bits)
//   addr_t             default-width register index (5 bits, 32 registers)
//   regfile_state_t    register file sequencer state: CLEAR or RUN
//   REGFILE_NREAD_MAX  largest supported number of read ports
package riscv;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef logic [XLEN_DEFAULT-1:0]          word_t;
    typedef logic [$clog2(NREGS_DEFAULT)-1:0] addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_t;

    localparam int REGFILE_NREAD_MAX = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register busy bits tracking writebacks that have been issued but not yet completed.
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   clear                drop every busy bit on the next edge (flush)
//   issue_en/issue_addr  mark a destination busy (already gated to RUN by the top)
//   wb_en/wb_addr        writeback completing this cycle (already gated to RUN)
//   rs_addr              flattened read addresses, NREAD x log2(NREGS)
//   rs_busy              per-port busy lookup, combinational
// Build option: REGFILE_BYPASS_EN selects whether an in-flight writeback hides the busy bit.
module regfile_scoreboard
    import riscv::*;
#(
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             issue_en,
    input  logic [$clog2(NREGS)-1:0]         issue_addr,
    input  logic                             wb_en,
    input  logic [$clog2(NREGS)-1:0]         wb_addr,
    input  logic [NREAD*$clog2(NREGS)-1:0]   rs_addr,
    output logic [NREAD-1:0]                 rs_busy
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] busy;

    function automatic logic hardwired(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Issue is applied after writeback so a same-cycle issue and writeback
    // to one register leaves it busy for the newly issued instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (clear) begin
            busy <= '0;
        end else begin
            if (wb_en && !hardwired(wb_addr)) begin
                busy[wb_addr] <= 1'b0;
            end
            if (issue_en && !hardwired(issue_addr)) begin
                busy[issue_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [AW-1:0] port_addr;
        logic          wb_hit;

        assign port_addr = rs_addr[i*AW +: AW];
        assign wb_hit    = wb_en && (wb_addr == port_addr) && !hardwired(port_addr);

`ifdef REGFILE_BYPASS_EN
        // The bypass forwards the writeback data, so the reader need not wait.
        assign rs_busy[i] = busy[port_addr] & ~wb_hit;
`else
        // Reads are read-first, so the reader must stall until the write lands.
        assign rs_busy[i] = busy[port_addr] | wb_hit;
`endif
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-read-port integer register file with a zero-clear sequencer, busy
// scoreboard and optional write-to-read bypass.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   flush                 restart the clear sequence
//   ready                 high while the file is in RUN
//   rs_addr / rs_data     flattened read ports (NREAD x log2(NREGS) / NREAD x XLEN), combinational
//   rs_busy               per-port pending-write flag, combinational
//   issue_en/issue_addr   mark a destination register busy
//   rd_en/rd_addr/rd_data single write port from writeback
// Build option: define REGFILE_BYPASS_EN for write-first reads; otherwise reads are read-first.
module regfile_mp
    import riscv::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    output logic                             ready,
    input  logic [NREAD*$clog2(NREGS)-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0]            rs_data,
    output logic [NREAD-1:0]                 rs_busy,
    input  logic                             issue_en,
    input  logic [$clog2(NREGS)-1:0]         issue_addr,
    input  logic                             rd_en,
    input  logic [$clog2(NREGS)-1:0]         rd_addr,
    input  logic [XLEN-1:0]                  rd_data
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    regfile_state_t state, state_next;
    logic [AW-1:0]  cnt;
    logic           run;
    logic           wr_ok;
    logic           iss_ok;
    logic [XLEN-1:0] regs [NREGS];

    function automatic logic hardwired(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next state: leave CLEAR once the last index has been zeroed
    always_comb begin
        state_next = state;
        case (state)
            CLEAR: if (!flush && cnt == LAST_IDX) state_next = RUN;
            RUN:   if (flush) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    // Sequencer outputs; writes and issues in a flush cycle are discarded
    always_comb begin
        run    = (state == RUN);
        ready  = run;
        wr_ok  = run && !flush && rd_en;
        iss_ok = run && !flush && issue_en;
    end

    // Clear counter sits at 0 in RUN so a flush always starts from index 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (flush || run || cnt == LAST_IDX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + AW'(1);
        end
    end

    // Storage has no reset; the sequencer zeroes it one index per cycle
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[cnt] <= '0;
        end else if (wr_ok && !hardwired(rd_addr)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0] port_addr;
        assign port_addr = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign rs_data[i*XLEN +: XLEN] =
            (!run || hardwired(port_addr))       ? '0      :
            (wr_ok && rd_addr == port_addr)      ? rd_data :
                                                   regs[port_addr];
`else
        assign rs_data[i*XLEN +: XLEN] =
            (!run || hardwired(port_addr)) ? '0 : regs[port_addr];
`endif
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (run && flush),
        .issue_en   (iss_ok),
        .issue_addr (issue_addr),
        .wb_en      (wr_ok),
        .wb_addr    (rd_addr),
        .rs_addr    (rs_addr),
        .rs_busy    (rs_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed self-checking bench for regfile_mp (XLEN=32, NREGS=32, NREAD=2, ZERO_REG=1).
// Expected values are queued when stimulus is driven and popped when the DUT output is sampled.
// Build option: REGFILE_BYPASS_EN changes the same-cycle read expectations.
module tb_regfile_mp;
    import riscv::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        ready;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        issue_en;
    addr_t       issue_addr;
    logic        rd_en;
    addr_t       rd_addr;
    word_t       rd_data;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .ready      (ready),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic apply_stimulus(input logic we, input addr_t wa, input word_t wd,
                                  input logic ie, input addr_t ia, input logic fl);
        rd_en      = we;
        rd_addr    = wa;
        rd_data    = wd;
        issue_en   = ie;
        issue_addr = ia;
        flush      = fl;
    endtask

    task automatic set_rs(input addr_t a0, input addr_t a1);
        rs_addr = {a1, a0};
    endtask

    // Steps through a full clear: ready must stay low for 31 samples and rise after the 32nd edge.
    task automatic wait_clear(input string tag);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            #1;
            expect_val({tag, "_ready"}, {31'd0, (k == 32)});
            check_output({31'd0, ready});
            expect_val({tag, "_rs0_zero"}, 32'h0);
            check_output(rs_data[31:0]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        set_rs(5'd5, 5'd5);
        repeat (3) @(negedge clk);
        #1;
        expect_val("reset_ready", 32'h0);
        check_output({31'd0, ready});
        expect_val("reset_busy", 32'h0);
        check_output({30'd0, rs_busy});

        // Release reset and watch the initial clear
        @(negedge clk);
        reset_n = 1'b1;
        wait_clear("init");

        // Write x7, read it back on port 1
        @(negedge clk);
        apply_stimulus(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        set_rs(5'd0, 5'd7);
        expect_val("x7_read", 32'hDEADBEEF);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output(rs_data[63:32]);

        // x0 is hardwired to zero
        @(negedge clk);
        apply_stimulus(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 1'b0);
        set_rs(5'd0, 5'd0);
        expect_val("x0_read_p0", 32'h0);
        expect_val("x0_read_p1", 32'h0);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output(rs_data[31:0]);
        check_output(rs_data[63:32]);

        // Same-cycle write and read of x3
        @(negedge clk);
        apply_stimulus(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
        set_rs(5'd3, 5'd7);
        #1;
        expect_val("x3_same_cycle_data", BYPASS ? 32'hA5A5A5A5 : 32'h11111111);
        check_output(rs_data[31:0]);
        expect_val("x3_same_cycle_busy", BYPASS ? 32'h0 : 32'h1);
        check_output({31'd0, rs_busy[0]});
        expect_val("x7_port1_during_write", 32'hDEADBEEF);
        check_output(rs_data[63:32]);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        set_rs(5'd3, 5'd3);
        #1;
        expect_val("x3_after_p0", 32'hA5A5A5A5);
        check_output(rs_data[31:0]);
        expect_val("x3_after_p1", 32'hA5A5A5A5);
        check_output(rs_data[63:32]);

        // Issue x9 marks it busy from the next cycle
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        set_rs(5'd9, 5'd9);
        #1;
        expect_val("x9_busy_before_edge", 32'h0);
        check_output({31'd0, rs_busy[0]});
        expect_val("x9_busy_after_issue", 32'h3);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output({30'd0, rs_busy});

        // Writeback of x9 clears its busy bit
        @(negedge clk);
        apply_stimulus(1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 1'b0);
        #1;
        expect_val("x9_busy_during_wb", BYPASS ? 32'h0 : 32'h1);
        check_output({31'd0, rs_busy[0]});
        expect_val("x9_busy_after_wb", 32'h0);
        expect_val("x9_data_after_wb", 32'h00000099);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output({31'd0, rs_busy[0]});
        check_output(rs_data[31:0]);

        // Simultaneous issue and writeback of x9: the issue wins
        @(negedge clk);
        apply_stimulus(1'b1, 5'd9, 32'h0000009A, 1'b1, 5'd9, 1'b0);
        expect_val("x9_issue_wb_busy", 32'h1);
        expect_val("x9_issue_wb_data", 32'h0000009A);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output({31'd0, rs_busy[0]});
        check_output(rs_data[31:0]);

        // Issue to x0 is ignored
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        set_rs(5'd0, 5'd9);
        expect_val("x0_issue_ignored", 32'h2);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output({30'd0, rs_busy});

        // Write x4, issue x12, then flush with a discarded write and issue
        @(negedge clk);
        apply_stimulus(1'b1, 5'd4, 32'h00000055, 1'b1, 5'd12, 1'b0);
        set_rs(5'd4, 5'd12);
        expect_val("x4_before_flush", 32'h00000055);
        expect_val("x12_busy_before_flush", 32'h1);
        @(negedge clk);
        apply_stimulus(1'b1, 5'd4, 32'h00000077, 1'b1, 5'd13, 1'b1);
        #1;
        check_output(rs_data[31:0]);
        check_output({31'd0, rs_busy[1]});
        expect_val("flush_ready", 32'h0);
        expect_val("flush_busy", 32'h0);
        expect_val("flush_clear_data", 32'h0);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output({31'd0, ready});
        check_output({30'd0, rs_busy});
        check_output(rs_data[31:0]);
        set_rs(5'd4, 5'd13);
        wait_clear("flush");
        #1;
        expect_val("x4_after_flush", 32'h0);
        check_output(rs_data[31:0]);
        expect_val("x13_not_busy", 32'h0);
        check_output({31'd0, rs_busy[1]});
        set_rs(5'd7, 5'd9);
        #1;
        expect_val("x7_after_flush", 32'h0);
        check_output(rs_data[31:0]);
        expect_val("x9_busy_after_flush", 32'h0);
        check_output({31'd0, rs_busy[1]});

        // Reset in the middle of a clear restarts the sequence
        @(negedge clk);
        apply_stimulus(1'b1, 5'd4, 32'h00000055, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        expect_val("midclear_reset_ready", 32'h0);
        check_output({31'd0, ready});
        @(negedge clk);
        reset_n = 1'b1;
        set_rs(5'd4, 5'd4);
        wait_clear("restart");
        #1;
        expect_val("x4_after_restart", 32'h0);
        check_output(rs_data[63:32]);

        // Asynchronous reset in RUN drops ready without a clock edge
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        expect_val("run_async_reset_ready", 32'h0);
        check_output({31'd0, ready});
        @(negedge clk);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
